btpipe_out_sched: RTL and testbench
===================================

# btpipe_out_sched

Block-granular round-robin scheduler that shares one okBTPipeOut endpoint among `N_SRC` internal first-word-fall-through sources. It asserts `ep_ready` only when the selected source holds a whole block, and locks the grant until that block has been read. It muxes and registers the selected source's words onto `ep_datain` and reports per-block progress for a wire-out. It sits between the producer FIFOs and the okBTPipeOut instance, in the `okClk` domain.

## Interface
- `N_SRC`, 4, number of requesting sources (2..8)
- `BLOCK_WORDS`, 4, 32-bit words per pipe block (16 bytes); power of two, ≥ 2
- `LVL_W`, 8, width of each source fill-level field
- `okClk`  in  1  host-interface clock; the only clock
- `rstn`  in  1  asynchronous, active-low reset
- `src_en`  in  N_SRC  per-source enable mask (from a wire-in)
- `src_level`  in  N_SRC*LVL_W  words available per source, source i at `[i*LVL_W +: LVL_W]`
- `src_data`  in  N_SRC*32  FWFT head word per source, source i at `[i*32 +: 32]`
- `src_rd`  out  N_SRC  one-hot pop strobe to the granted source
- `ep_read`  in  1  okBTPipeOut read strobe
- `ep_blockstrobe`  in  1  okBTPipeOut block-start strobe (monitored only)
- `ep_ready`  out  1  to okBTPipeOut
- `ep_datain`  out  32  to okBTPipeOut
- `cur_src`  out  3  granted source index
- `busy`  out  1  high while a block is granted
- `blk_done`  out  1  one-cycle pulse when a block completes
- `blk_count`  out  16  completed blocks, wraps
- `underrun`  out  1  sticky: `ep_read` seen while not granted

## Operation
- Source i is eligible when `src_en[i]` is high and `src_level[i] >= BLOCK_WORDS`.
- States: IDLE, XFER.
- IDLE behaviour:
  - If any source is eligible, the round-robin winner is chosen, starting the search at `ptr`.
  - On that edge: `cur_src` <= winner, `ep_ready` <= 1, `word_cnt` <= 0, state <= XFER.
  - If no source is eligible, the block stays in IDLE with `ep_ready` low.
- XFER behaviour:
  - On each `ep_read`: `src_rd[cur_src]` = 1 combinationally in the same cycle, `ep_datain` <= `src_data[cur_src]`, `word_cnt` increments.
  - On the `ep_read` where `word_cnt == BLOCK_WORDS-1`: `ep_ready` <= 0, `blk_done` <= 1, `blk_count` increments, `ptr` <= (`cur_src`+1) mod `N_SRC`, state <= IDLE.
- Grant lock: changes to `src_en` or `src_level` during XFER have no effect until the block completes.
- `ep_read` in IDLE:
  - `src_rd` stays 0.
  - `ep_datain` <= 0x00000000.
  - `underrun` <= 1, cleared only by reset.
- `ep_blockstrobe` does not change state. It is used only for bench checking.
- `blk_count` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values:
  - `ep_ready` 0, `ep_datain` 0, `cur_src` 0, `busy` 0, `blk_done` 0, `blk_count` 0, `underrun` 0.
  - `src_rd` 0, `ptr` 0, state IDLE, `word_cnt` 0.
- Reset is asynchronous. Assertion mid-block abandons the block immediately; the source keeps its unread words.
- Latency from a source becoming eligible in IDLE to `ep_ready` high: 1 cycle.
- `ep_datain` holds the popped word from the cycle after `ep_read`, matching the okBTPipeOut read timing.
- Between consecutive blocks `ep_ready` is low for at least one cycle; back-to-back blocks cost one IDLE cycle each.
- `busy` equals (state == XFER). `blk_done` coincides with the first IDLE cycle.
- Simultaneous eligibility: the lowest index at or after `ptr` wins, wrapping modulo `N_SRC`.

## Structure
- Package `btpipe_pkg`:
  - `EP_W` = 32
  - default `BLOCK_WORDS`
  - state enum (IDLE, XFER)
  - `CNT_W` = 16
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector, `ptr`.
  - Outputs: `valid`, winner index.
  - The scheduler registers the picker's result.

## Test plan
- Reset, then source 0 enabled with level 4 and others empty: `ep_ready` rises 1 cycle later. Four `ep_read` strobes pop 0xA0..0xA3 in order. `blk_done` pulses once, `blk_count`=1, `ep_ready` low.
- Sources 0..3 all eligible with 8 words each: grant order 0,1,2,3,0,1,2,3. `ep_ready` is low for one cycle between blocks. `blk_count`=8.
- Source 2 at level 3 (not eligible), then raised to 4: no `ep_ready` until the raise, then `ep_ready` 1 cycle later with `cur_src`=2.
- `src_en[1]` cleared after 2 of 4 reads of a source-1 block: the block completes all 4 words. Source 1 is not granted again while its enable is low.
- `ep_read` pulsed in IDLE: `ep_datain`=0, `underrun`=1 and stays 1, no `src_rd`, `blk_count` unchanged.
- `rstn` asserted after 2 reads: all outputs return to reset values within the same cycle. After release, source 0 is re-granted with `ptr`=0.

Source files
------------

// File: rtl/btpipe_pkg.sv
// Shared types and constants for the okBTPipeOut block scheduler.
package btpipe_pkg;

    localparam int EP_W            = 32;
    localparam int CNT_W           = 16;
    localparam int BLOCK_WORDS_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/btpipe_out_sched_rr_pick.sv
// Combinational round-robin picker: lowest request index at or after ptr wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int c;

    // Walk offsets from far to near so the closest request to ptr is written last.
    always_comb begin
        valid = |req;
        idx   = '0;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) idx = IDX_W'(c);
        end
    end

endmodule

// File: rtl/btpipe_out_sched.sv
// Block-granular round-robin scheduler sharing one okBTPipeOut among N_SRC FWFT sources.
module btpipe_out_sched
    import btpipe_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int LVL_W       = 8
) (
    input  logic                   okClk,
    input  logic                   rstn,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*LVL_W-1:0] src_level,
    input  logic [N_SRC*EP_W-1:0]  src_data,
    output logic [N_SRC-1:0]       src_rd,
    input  logic                   ep_read,
    input  logic                   ep_blockstrobe,
    output logic                   ep_ready,
    output logic [EP_W-1:0]        ep_datain,
    output logic [2:0]             cur_src,
    output logic                   busy,
    output logic                   blk_done,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   underrun
);

    localparam int WC_W = $clog2(BLOCK_WORDS);

    state_t            state, state_nxt;
    logic [2:0]        ptr;
    logic [2:0]        ptr_nxt;
    logic [WC_W-1:0]   word_cnt;
    logic [N_SRC-1:0]  eligible;
    logic              pick_valid;
    logic [2:0]        pick_idx;
    logic [EP_W-1:0]   sel_data;
    logic              last_word;
    logic              unused_strobe;

    // The block strobe is informational only; the scheduler counts reads itself.
    assign unused_strobe = ep_blockstrobe;

    always_comb begin
        eligible = '0;
        sel_data = '0;
        src_rd   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = src_en[i] &&
                          (32'(src_level[i*LVL_W +: LVL_W]) >= 32'(BLOCK_WORDS));
            if (cur_src == 3'(i)) sel_data = src_data[i*EP_W +: EP_W];
            src_rd[i] = (state == XFER) && ep_read && (cur_src == 3'(i));
        end
    end

    rr_pick #(.N(N_SRC), .IDX_W(3)) u_pick (
        .req   (eligible),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign last_word = (word_cnt == WC_W'(BLOCK_WORDS - 1));
    assign ptr_nxt   = (cur_src == 3'(N_SRC - 1)) ? 3'd0 : cur_src + 3'd1;
    assign busy      = (state == XFER);

    always_ff @(posedge okClk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = XFER;
            XFER:    if (ep_read && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is captured once per block; eligibility is ignored until the last read.
    always_ff @(posedge okClk or negedge rstn) begin
        if (!rstn) begin
            ep_ready  <= 1'b0;
            ep_datain <= '0;
            cur_src   <= '0;
            blk_done  <= 1'b0;
            blk_count <= '0;
            underrun  <= 1'b0;
            ptr       <= '0;
            word_cnt  <= '0;
        end else begin
            blk_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ep_read) begin
                        ep_datain <= '0;
                        underrun  <= 1'b1;
                    end
                    if (pick_valid) begin
                        cur_src  <= pick_idx;
                        ep_ready <= 1'b1;
                        word_cnt <= '0;
                    end
                end
                XFER: begin
                    if (ep_read) begin
                        ep_datain <= sel_data;
                        word_cnt  <= word_cnt + 1'b1;
                        if (last_word) begin
                            ep_ready  <= 1'b0;
                            blk_done  <= 1'b1;
                            blk_count <= blk_count + 1'b1;
                            ptr       <= ptr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btpipe_out_sched.sv
// Self-checking bench for btpipe_out_sched with FWFT source models and a word scoreboard.
module tb_btpipe_out_sched;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int LW = 8;
    localparam int DEPTH = 64;

    logic            okClk;
    logic            rstn;
    logic [N-1:0]    src_en;
    logic [N*LW-1:0] src_level;
    logic [N*32-1:0] src_data;
    logic [N-1:0]    src_rd;
    logic            ep_read;
    logic            ep_blockstrobe;
    logic            ep_ready;
    logic [31:0]     ep_datain;
    logic [2:0]      cur_src;
    logic            busy;
    logic            blk_done;
    logic [15:0]     blk_count;
    logic            underrun;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [N][DEPTH];
    int          head [N];
    int          tail [N];
    logic [N-1:0] rd_snap;
    logic [31:0] exp_q [$];

    btpipe_out_sched #(.N_SRC(N), .BLOCK_WORDS(BW), .LVL_W(LW)) dut (
        .okClk          (okClk),
        .rstn           (rstn),
        .src_en         (src_en),
        .src_level      (src_level),
        .src_data       (src_data),
        .src_rd         (src_rd),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_ready       (ep_ready),
        .ep_datain      (ep_datain),
        .cur_src        (cur_src),
        .busy           (busy),
        .blk_done       (blk_done),
        .blk_count      (blk_count),
        .underrun       (underrun)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            src_level[i*LW +: LW] = LW'(tail[i] - head[i]);
            src_data[i*32 +: 32]  = (tail[i] > head[i]) ? mem[i][head[i]] : 32'h0;
        end
    endtask

    task automatic load(input int s, input int n);
        for (int j = 0; j < n; j++) begin
            mem[s][tail[s]] = 32'hA0 + 32'(s) * 32'h100 + 32'(tail[s]);
            tail[s]++;
        end
        refresh();
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        rd_snap = src_rd;
        @(posedge okClk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd_snap[i] && head[i] < tail[i]) head[i]++;
        refresh();
        @(negedge okClk);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!ep_ready && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (!ep_ready) begin
            bad++;
            $display("FAIL wait_grant: ep_ready=%0b after %0d cycles, required 1", ep_ready, n);
        end
    endtask

    task automatic read_block(input int s);
        logic [31:0] e;
        for (int k = 0; k < BW; k++) begin
            ep_read = 1'b1;
            exp_q.push_back(mem[s][head[s]]);
            cycle();
            e = exp_q.pop_front();
            total++; if (ep_datain !== e) begin bad++; $display("FAIL word src%0d[%0d]: ep_datain=%h required %h", s, k, ep_datain, e); end
            total++; if (rd_snap !== N'(1 << s)) begin bad++; $display("FAIL src_rd src%0d[%0d]: got %b required %b", s, k, rd_snap, N'(1 << s)); end
            if (k == BW - 1) begin
                total++; if (blk_done !== 1'b1) begin bad++; $display("FAIL blk_done end src%0d: got %b required 1", s, blk_done); end
                total++; if (ep_ready !== 1'b0) begin bad++; $display("FAIL ready low end src%0d: got %b required 0", s, ep_ready); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy end src%0d: got %b required 0", s, busy); end
            end else begin
                total++; if (blk_done !== 1'b0 || ep_ready !== 1'b1) begin bad++; $display("FAIL mid block src%0d[%0d]: done=%b ready=%b required 0/1", s, k, blk_done, ep_ready); end
            end
        end
        ep_read = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (ep_ready !== 1'b0 || ep_datain !== 32'h0 || cur_src !== 3'd0 || busy !== 1'b0 ||
            blk_done !== 1'b0 || blk_count !== 16'h0 || underrun !== 1'b0 || src_rd !== '0) begin
            bad++;
            $display("FAIL %s: ready=%b data=%h cur=%0d busy=%b done=%b cnt=%0d und=%b rd=%b required all zero",
                     tag, ep_ready, ep_datain, cur_src, busy, blk_done, blk_count, underrun, src_rd);
        end
    endtask

    task automatic do_reset();
        ep_read = 1'b0;
        rstn    = 1'b0;
        #1;
        check_reset_vals("reset_values");
        @(negedge okClk);
        @(negedge okClk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        ep_read = 1'b1;
        rstn    = 1'b0;
        @(negedge okClk);
        check_reset_vals("reset_with_read");
        ep_read = 1'b0;
        rstn    = 1'b1;
    endtask

    task automatic test_single();
        int n;
        src_en = 4'b0001;
        load(0, 4);
        cycle();
        total++; if (ep_ready !== 1'b1 || cur_src !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL single_grant: ready=%b cur=%0d busy=%b required 1/0/1", ep_ready, cur_src, busy); end
        read_block(0);
        total++; if (blk_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d required 1", blk_count); end
        cycle();
        total++; if (blk_done !== 1'b0 || ep_ready !== 1'b0) begin bad++; $display("FAIL single_after: done=%b ready=%b required 0/0", blk_done, ep_ready); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int s = 0; s < N; s++) load(s, 8);
        src_en = 4'b1111;
        for (int b = 0; b < 8; b++) begin
            wait_grant(n);
            total++; if (cur_src !== 3'(b % N)) begin bad++; $display("FAIL rr_order blk%0d: cur_src=%0d required %0d", b, cur_src, b % N); end
            if (b > 0) begin
                total++; if (n !== 1) begin bad++; $display("FAIL rr_gap blk%0d: idle cycles=%0d required 1", b, n); end
            end
            read_block(b % N);
        end
        total++; if (blk_count !== 16'd8) begin bad++; $display("FAIL rr_count: got %0d required 8", blk_count); end
    endtask

    task automatic test_eligibility();
        do_reset();
        src_en = 4'b0100;
        load(2, 3);
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++; if (ep_ready !== 1'b0) begin bad++; $display("FAIL level3_noready c%0d: got %b required 0", c, ep_ready); end
        end
        load(2, 1);
        cycle();
        total++; if (ep_ready !== 1'b1 || cur_src !== 3'd2) begin bad++; $display("FAIL level4_grant: ready=%b cur=%0d required 1/2", ep_ready, cur_src); end
        read_block(2);
    endtask

    task automatic test_lock();
        int n;
        logic [31:0] e;
        src_en = 4'b0010;
        load(1, 4);
        wait_grant(n);
        total++; if (cur_src !== 3'd1) begin bad++; $display("FAIL lock_grant: cur_src=%0d required 1", cur_src); end
        for (int k = 0; k < BW; k++) begin
            if (k == 2) src_en = 4'b0000;
            ep_read = 1'b1;
            exp_q.push_back(mem[1][head[1]]);
            cycle();
            e = exp_q.pop_front();
            total++; if (ep_datain !== e || rd_snap !== 4'b0010) begin bad++; $display("FAIL lock_word[%0d]: data=%h rd=%b required %h/0010", k, ep_datain, rd_snap, e); end
        end
        ep_read = 1'b0;
        total++; if (blk_done !== 1'b1) begin bad++; $display("FAIL lock_done: got %b required 1", blk_done); end
        load(1, 4);
        for (int c = 0; c < 4; c++) begin
            cycle();
            total++; if (ep_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL lock_disabled c%0d: ready=%b busy=%b required 0/0", c, ep_ready, busy); end
        end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clean: got %b required 0", underrun); end
    endtask

    task automatic test_idle_read();
        logic [15:0] cnt0;
        cnt0 = blk_count;
        ep_read = 1'b1;
        cycle();
        ep_read = 1'b0;
        total++; if (ep_datain !== 32'h0) begin bad++; $display("FAIL idle_read_data: got %h required 00000000", ep_datain); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL idle_read_underrun: got %b required 1", underrun); end
        total++; if (rd_snap !== '0) begin bad++; $display("FAIL idle_read_rd: got %b required 0000", rd_snap); end
        total++; if (blk_count !== cnt0) begin bad++; $display("FAIL idle_read_count: got %0d required %0d", blk_count, cnt0); end
        cycle();
        cycle();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b required 1", underrun); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] e;
        load(0, 4);
        load(3, 4);
        src_en = 4'b1001;
        wait_grant(n);
        total++; if (cur_src !== 3'd3) begin bad++; $display("FAIL mid_pre_grant: cur_src=%0d required 3", cur_src); end
        for (int k = 0; k < 2; k++) begin
            ep_read = 1'b1;
            exp_q.push_back(mem[3][head[3]]);
            cycle();
            e = exp_q.pop_front();
            total++; if (ep_datain !== e) begin bad++; $display("FAIL mid_word[%0d]: got %h required %h", k, ep_datain, e); end
        end
        do_reset();
        load(3, 2);
        wait_grant(n);
        total++; if (cur_src !== 3'd0 || n !== 1) begin bad++; $display("FAIL post_reset_grant: cur=%0d cycles=%0d required 0/1", cur_src, n); end
        read_block(0);
        wait_grant(n);
        total++; if (cur_src !== 3'd3) begin bad++; $display("FAIL post_reset_src3: cur_src=%0d required 3", cur_src); end
        read_block(3);
        total++; if (blk_count !== 16'd2) begin bad++; $display("FAIL post_reset_count: got %0d required 2", blk_count); end
    endtask

    initial begin
        rstn           = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        src_en         = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        refresh();
        @(negedge okClk);
        test_reset();
        test_single();
        test_round_robin();
        test_eligibility();
        test_lock();
        test_idle_read();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
